id_ex_pipe_stage: RTL
=====================

ID_EX_PIPE_STAGE -- requirements
Module: id_ex_pipe_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, width of the PC, operand and immediate fields.
REQ-002 The block SHALL have parameter NUM_OPS, default 2, the number of register-file operand channels, legal range 1..4.
REQ-003 The block SHALL have parameter CTRL_W, default 8, width of the packed control bundle: {branch, reg_write, mem_to_reg, mem_write, mem_read, alu_src, alu_op[1:0]} at the default.
REQ-004 The block SHALL have parameter RD_W, default 5, width of the destination-register index.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  ID stage presents a valid bundle.
REQ-008 in_ready  output  1  stage can accept a bundle this cycle.
REQ-009 in_nextpc  input  DATA_W  PC+4 of the instruction.
REQ-010 in_ops  input  NUM_OPS*DATA_W  operand channels; channel k at bits [k*DATA_W +: DATA_W].
REQ-011 in_imm  input  DATA_W  sign-extended immediate.
REQ-012 in_ctrl  input  CTRL_W  control bundle.
REQ-013 in_rd  input  RD_W  destination register index.
REQ-014 flush  input  1  discard every held and incoming bundle (branch taken / hazard squash).
REQ-015 out_valid  output  1  EX-side bundle valid.
REQ-016 out_ready  input  1  EX stage consumes the bundle this cycle.
REQ-017 out_nextpc, out_ops, out_imm, out_ctrl, out_rd  outputs  widths as the matching inputs  registered bundle.
REQ-018 occupancy  output  2  number of bundles held (0..2).

Function
REQ-019 An input transfer SHALL occur on a rising edge with in_valid && in_ready && !flush; an output transfer SHALL occur with out_valid && out_ready.
REQ-020 Latency SHALL be exactly one cycle: a bundle accepted at edge N SHALL appear on out_* with out_valid=1 after edge N when the stage was empty.
REQ-021 Throughput SHALL be one bundle per cycle while out_ready stays 1.
REQ-022 With out_valid=1 and out_ready=0, all out_* SHALL hold their values (stall).
REQ-023 Bundles SHALL leave in acceptance order; none dropped or duplicated except by flush.
REQ-024 When out_valid=0, out_ctrl SHALL read all-zero (bubble: no reg_write, no mem_write); data outputs are don't-care.
REQ-025 flush=1 at an edge SHALL clear all held bundles (occupancy→0, out_valid→0) and discard any simultaneous input; flush overrides in_valid, out_ready and stall.
REQ-026 Output transfer and input transfer in the same cycle SHALL leave occupancy unchanged (full/empty boundary included).
REQ-027 Operand channels SHALL be carried bit-exact; no arithmetic or width conversion.

Reset
REQ-028 reset low SHALL immediately, without clk, force out_valid=0, occupancy=0, out_ctrl=0, out_rd=0, out_nextpc=0, out_ops=0, out_imm=0.
REQ-029 in_ready SHALL be 0 while reset is low and SHALL be 1 on the first edge after release.
REQ-030 Reset asserted mid-stall SHALL discard held bundles identically to REQ-028.

Configuration
REQ-031 Macro ID_EX_SKID_EN defined: the stage SHALL be a 2-entry skid buffer; in_ready SHALL be a register output equal to (occupancy<2); occupancy reaches 2 when a bundle is accepted while output stalls.
REQ-032 Macro ID_EX_SKID_EN undefined: the stage SHALL be a single register; in_ready = out_ready || !out_valid (combinational); occupancy never exceeds 1.

Verification
REQ-033 Reset low mid-run with out_valid=1 -> outputs zero and out_valid=0 before next clk edge; first edge after release in_ready=1.
REQ-034 Stream in_nextpc 0x4,0x8,0xC back-to-back, out_ready=1 -> same values on out_nextpc on consecutive cycles, one cycle later each.
REQ-035 Accept 0x100, hold out_ready=0 for 3 cycles -> out_nextpc stays 0x100; with SKID_EN next bundle 0x104 accepted, occupancy=2, in_ready=0; release -> 0x100 then 0x104.
REQ-036 flush=1 with occupancy=2 and in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0x00, incoming bundle absent.
REQ-037 NUM_OPS=3, in_ops channels 0xAAAA_0001/0xBBBB_0002/0xCCCC_0003 -> identical channels on out_ops.
REQ-038 in_valid=0 for a cycle between bundles -> out_valid=0 and out_ctrl=0x00 in the bubble cycle.

Source files
------------

// File: rtl/id_ex_pipe_stage.sv
// ============================================================================
// Module      : id_ex_pipe_stage
// Description : ID->EX pipeline register with valid/ready handshake and flush.
//               Define ID_EX_SKID_EN for a 2-entry skid buffer with a
//               registered in_ready; otherwise a single register stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_pipe_stage #(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 2,
    parameter int CTRL_W  = 8,
    parameter int RD_W    = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_nextpc,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    input  logic [DATA_W-1:0]         in_imm,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [RD_W-1:0]           in_rd,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_nextpc,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [DATA_W-1:0]         out_imm,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [RD_W-1:0]           out_rd,
    output logic [1:0]                occupancy
);

    localparam int c_BUNDLE_W = DATA_W * (NUM_OPS + 2) + CTRL_W + RD_W;

    logic [c_BUNDLE_W-1:0] w_in_bundle;
    logic [c_BUNDLE_W-1:0] r_head;
    logic [CTRL_W-1:0]     w_head_ctrl;
    logic [1:0]            r_occ;
    logic [1:0]            w_occ_nxt;
    logic                  r_rdy;
    logic                  w_out_valid;
    logic                  w_in_xfer;
    logic                  w_out_xfer;

    assign w_in_bundle = {in_nextpc, in_ops, in_imm, in_ctrl, in_rd};
    assign w_out_valid = (r_occ != 2'd0);
    assign w_in_xfer   = in_valid && in_ready && !flush;
    assign w_out_xfer  = w_out_valid && out_ready;

    always_comb begin
        w_occ_nxt = r_occ;
        if (flush) begin
            w_occ_nxt = 2'd0;
        end else if (w_in_xfer && !w_out_xfer) begin
            w_occ_nxt = r_occ + 2'd1;
        end else if (!w_in_xfer && w_out_xfer) begin
            w_occ_nxt = r_occ - 2'd1;
        end
    end

`ifdef ID_EX_SKID_EN
    logic [c_BUNDLE_W-1:0] r_skid;

    // The skid entry only fills while the head is stalled; it drains into the head first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ  <= 2'd0;
            r_rdy  <= 1'b0;
            r_head <= '0;
            r_skid <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            r_rdy <= (w_occ_nxt != 2'd2);
            if (!flush) begin
                if (r_occ == 2'd2 && w_out_xfer) begin
                    r_head <= r_skid;
                end else if (w_in_xfer && (r_occ == 2'd0 || w_out_xfer)) begin
                    r_head <= w_in_bundle;
                end else if (w_in_xfer) begin
                    r_skid <= w_in_bundle;
                end
            end
        end
    end

    assign in_ready = r_rdy;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ  <= 2'd0;
            r_rdy  <= 1'b0;
            r_head <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            r_rdy <= 1'b1;
            if (w_in_xfer) begin
                r_head <= w_in_bundle;
            end
        end
    end

    // r_rdy keeps the stage closed until the first edge after reset release.
    assign in_ready = r_rdy && (out_ready || !w_out_valid);
`endif

    assign {out_nextpc, out_ops, out_imm, w_head_ctrl, out_rd} = r_head;
    assign out_ctrl  = w_out_valid ? w_head_ctrl : '0;
    assign out_valid = w_out_valid;
    assign occupancy = r_occ;

endmodule

`default_nettype wire
